sync_fifo_ext: RTL and testbench

- Parametrised synchronous FIFO:
  - arbitrary (non-power-of-two) depth;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - fill-level output and programmable almost-full/almost-empty thresholds;
  - sticky overflow/underflow error flags and a synchronous flush.
- Drop-in successor to the existing `fifo` for delay-line buffering paths that need occupancy reporting and zero-latency head visibility.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ram.sv | 25 ++
 rtl/sync_fifo_ext.sv | 124 ++++++++++++
 tb/tb_sync_fifo_ext.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO family.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_t;

    function automatic int fifo_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with arbitrary depth, STD/FWFT read modes, fill-level
// reporting, almost-full/empty thresholds, sticky error flags and flush.
module sync_fifo_ext
    import fifo_pkg::*;
#(
    parameter int         WIDTH         = 8,
    parameter int         DEPTH         = 10,
    parameter fifo_mode_t MODE          = FIFO_STD,
    parameter int         AFULL_THRESH  = DEPTH - 2,
    parameter int         AEMPTY_THRESH = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               wr_en,
    input  logic [WIDTH-1:0]                   data_in,
    input  logic                               rd_en,
    output logic [WIDTH-1:0]                   data_out,
    output logic                               empty,
    output logic                               full,
    output logic                               almost_empty,
    output logic                               almost_full,
    output logic [fifo_count_width(DEPTH)-1:0] count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int CW = fifo_count_width(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] ram_rdata;
    logic             empty_w, full_w;
    logic             wr_acc, rd_acc;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));

    // A read frees the head slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign rd_acc = rd_en && !empty_w && !flush;
    assign wr_acc = wr_en && (!full_w || rd_en) && !flush;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        dout_d      = dout_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
                dout_d   = ram_rdata;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_en && full_w && !rd_en) begin
                overflow_d = 1'b1;
            end
            if (rd_en && empty_w) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
        end
    end

    assign data_out     = (MODE == FIFO_FWFT) ? ram_rdata : dout_q;
    assign empty        = empty_w;
    assign full         = full_w;
    assign almost_empty = (int'(count_q) <= AEMPTY_THRESH);
    assign almost_full  = (int'(count_q) >= AFULL_THRESH);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed self-checking bench for sync_fifo_ext in STD and FWFT modes.
module tb_sync_fifo_ext;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       reset;

    logic       flush, wr_en, rd_en;
    logic [7:0] data_in, data_out;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;
    logic [3:0] count;

    logic       f_flush, f_wr_en, f_rd_en;
    logic [7:0] f_data_in, f_data_out;
    logic       f_empty, f_full, f_almost_empty, f_almost_full, f_overflow, f_underflow;
    logic [3:0] f_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_fifo_ext #(
        .WIDTH         (8),
        .DEPTH         (10),
        .MODE          (FIFO_STD),
        .AFULL_THRESH  (8),
        .AEMPTY_THRESH (2)
    ) u_std (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    sync_fifo_ext #(
        .WIDTH         (8),
        .DEPTH         (10),
        .MODE          (FIFO_FWFT),
        .AFULL_THRESH  (8),
        .AEMPTY_THRESH (2)
    ) u_fwft (
        .clk          (clk),
        .reset        (reset),
        .flush        (f_flush),
        .wr_en        (f_wr_en),
        .data_in      (f_data_in),
        .rd_en        (f_rd_en),
        .data_out     (f_data_out),
        .empty        (f_empty),
        .full         (f_full),
        .almost_empty (f_almost_empty),
        .almost_full  (f_almost_full),
        .count        (f_count),
        .overflow     (f_overflow),
        .underflow    (f_underflow)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        data_in = '0; f_data_in = '0;
        idle();
        cyc(); cyc();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if ({almost_empty, almost_full} !== 2'b10) begin errors++; $display("FAIL reset_almost: got %b expected 10", {almost_empty, almost_full}); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_errors: got %b expected 00", {overflow, underflow}); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", data_out); end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 10; i++) begin
            wr_en = 1'b1; data_in = 8'(i);
            cyc();
            checks++; if (count !== 4'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); end
            checks++; if (almost_empty !== (i <= 2)) begin errors++; $display("FAIL fill_aempty[%0d]: got %b expected %b", i, almost_empty, (i <= 2)); end
            checks++; if (almost_full !== (i >= 8)) begin errors++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, almost_full, (i >= 8)); end
            checks++; if (full !== (i == 10)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 10)); end
        end
        data_in = 8'hFF;
        cyc();
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (count !== 4'd10) begin errors++; $display("FAIL ovf_count: got %0d expected 10", count); end
    endtask

    task automatic test_std_drain();
        for (int i = 1; i <= 10; i++) begin
            rd_en = 1'b1;
            cyc();
            checks++; if (data_out !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, 8'(i)); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
        cyc();
        rd_en = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b expected 1", underflow); end
        checks++; if (data_out !== 8'h0A) begin errors++; $display("FAIL unf_hold: got %h expected 0a", data_out); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL unf_count: got %0d expected 0", count); end
    endtask

    task automatic test_wrap();
        int rd_idx = 0;
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1; data_in = 8'h30 + 8'(k);
            cyc();
        end
        for (int k = 5; k < 25; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h30 + 8'(k);
            cyc();
            checks++; if (data_out !== 8'h30 + 8'(rd_idx)) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", rd_idx, data_out, 8'h30 + 8'(rd_idx)); end
            checks++; if (count !== 4'd5) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected 5", k, count); end
            rd_idx++;
        end
        wr_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rd_en = 1'b1;
            cyc();
            checks++; if (data_out !== 8'h30 + 8'(rd_idx)) begin errors++; $display("FAIL wrap_tail[%0d]: got %h expected %h", rd_idx, data_out, 8'h30 + 8'(rd_idx)); end
            rd_idx++;
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1; data_in = 8'h11 + 8'(k);
            cyc();
        end
        wr_en = 1'b0;
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
        checks++; if ({overflow, underflow} !== 2'b11) begin errors++; $display("FAIL flush_pre_errors: got %b expected 11", {overflow, underflow}); end
        flush = 1'b1; wr_en = 1'b1; data_in = 8'hEE;
        cyc();
        flush = 1'b0; wr_en = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", empty); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL flush_errors: got %b expected 00", {overflow, underflow}); end
        checks++; if (data_out !== 8'h48) begin errors++; $display("FAIL flush_dout: got %h expected 48", data_out); end
    endtask

    task automatic test_full_rw();
        for (int k = 0; k < 10; k++) begin
            wr_en = 1'b1; data_in = 8'h61 + 8'(k);
            cyc();
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL frw_full: got %b expected 1", full); end
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hAA;
        cyc();
        wr_en = 1'b0;
        checks++; if (count !== 4'd10) begin errors++; $display("FAIL frw_count: got %0d expected 10", count); end
        checks++; if (data_out !== 8'h61) begin errors++; $display("FAIL frw_data: got %h expected 61", data_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL frw_ovf: got %b expected 0", overflow); end
        for (int k = 1; k <= 10; k++) begin
            rd_en = 1'b1;
            cyc();
            checks++;
            if (data_out !== ((k == 10) ? 8'hAA : 8'h61 + 8'(k))) begin
                errors++;
                $display("FAIL frw_drain[%0d]: got %h expected %h", k, data_out, ((k == 10) ? 8'hAA : 8'h61 + 8'(k)));
            end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL frw_empty: got %b expected 1", empty); end
    endtask

    task automatic test_fwft();
        f_wr_en = 1'b1; f_data_in = 8'h5A;
        cyc();
        f_wr_en = 1'b0;
        checks++; if (f_empty !== 1'b0) begin errors++; $display("FAIL fwft_empty: got %b expected 0", f_empty); end
        checks++; if (f_data_out !== 8'h5A) begin errors++; $display("FAIL fwft_head: got %h expected 5a", f_data_out); end
        f_rd_en = 1'b1;
        cyc();
        f_rd_en = 1'b0;
        checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fwft_pop_empty: got %b expected 1", f_empty); end
        checks++; if (f_count !== 4'd0) begin errors++; $display("FAIL fwft_pop_count: got %0d expected 0", f_count); end
        f_wr_en = 1'b1; f_data_in = 8'h5B;
        cyc();
        f_data_in = 8'h5C;
        cyc();
        f_wr_en = 1'b0;
        checks++; if (f_data_out !== 8'h5B) begin errors++; $display("FAIL fwft_head2: got %h expected 5b", f_data_out); end
        f_rd_en = 1'b1;
        cyc();
        f_rd_en = 1'b0;
        checks++; if (f_data_out !== 8'h5C) begin errors++; $display("FAIL fwft_head3: got %h expected 5c", f_data_out); end
        checks++; if (f_count !== 4'd1) begin errors++; $display("FAIL fwft_count3: got %0d expected 1", f_count); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; data_in = 8'h71 + 8'(k);
            cyc();
        end
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL ares_pre_count: got %0d expected 4", count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ares_empty: got %b expected 1", empty); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL ares_count: got %0d expected 0", count); end
        wr_en = 1'b0;
        cyc();
        reset = 1'b0;
        wr_en = 1'b1; data_in = 8'h99;
        cyc();
        wr_en = 1'b0;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL ares_resume: got %0d expected 1", count); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_std_drain();
        test_wrap();
        test_flush();
        test_full_rw();
        test_fwft();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
